instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32I instruction encoder and program loader for the single-cycle core. It accepts instruction fields for the four classes the main decoder recognises (LW, SW, R-type, BEQ) over a valid/ready handshake. It assembles the 32-bit word with the opcode and immediate layout the decoder expects and writes it into instruction memory at consecutive word addresses. It is the producing end of the opcode/immediate format that the main decoder and immediate extender consume.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_kind  in  2  00 LW, 01 SW, 10 R-type, 11 BEQ
- rd, rs1, rs2  in  5 each  register fields; unused fields ignored per kind
- funct3  in  3  R-type only; LW/SW force 010, BEQ forces 000
- funct7b5  in  1  R-type bit 30 (sub/sra); ignored otherwise
- imm  in  13  signed immediate; LW/SW use [11:0], BEQ uses [12:1]
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset
- full  out  1  count == 2^ADDR_W
- err  out  1  one-cycle pulse: accepted bundle rejected

## Operation
- Encodings, MSB first:
  - LW: imm[11:0], rs1, 010, rd, 0000011
  - SW: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011
  - R-type: 0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011
  - BEQ: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011
- States:
  - IDLE: in_ready = !full. An accept is in_valid && in_ready at a rising edge.
    - Legal bundle: register mem_wdata, set mem_addr = wr_ptr, assert mem_we, go to WRITE.
    - Illegal bundle (see Configuration): pulse err, stay in IDLE, no write, pointer unchanged.
  - WRITE: mem_we = 1 for exactly this cycle; in_ready = 0. Next edge: wr_ptr++, count++, mem_we = 0. Go to IDLE, or to FULL if count reaches 2^ADDR_W.
  - FULL: in_ready = 0, full = 1. Input is ignored. Only reset exits this state.
- wr_ptr is ADDR_W bits. The transition to FULL prevents wrap, so address 0 is never overwritten.
- in_valid while in_ready = 0: no effect. The producer must hold the bundle.

## Timing
- Reset values: state IDLE, wr_ptr 0, count 0, mem_we 0, mem_addr 0, mem_wdata 0, err 0, full 0. in_ready is 1 in the first cycle after reset.
- All outputs are registered except in_ready, which is combinational from state.
- Latency: accept at edge N. During cycle N..N+1, mem_we = 1 and mem_addr/mem_wdata are valid. count updates at edge N+1.
- Throughput: one word per 2 cycles. in_ready is 0 for the WRITE cycle.
- err is asserted during cycle N..N+1 after a rejected accept. Back-to-back rejects produce consecutive err pulses.
- Reset asserted during WRITE: mem_we is 0 from the next cycle, the write is not counted, and the pointer returns to 0.

## Configuration
- ENC_IMM_CHECK_EN defined:
  - LW/SW require imm[12] == imm[11] (12-bit signed range); otherwise the bundle is rejected.
  - BEQ requires imm[0] == 0; otherwise the bundle is rejected.
  - Rejection: err pulse, no write.
- ENC_IMM_CHECK_EN undefined:
  - No checks. Immediates are silently truncated to the encoded bits.
  - err is tied to 0 and no bundle is ever rejected.

## Test plan
- Reset, then LW rd=5 rs1=2 imm=8 -> mem_we one cycle, mem_addr=0, mem_wdata=0x00812283, count=1.
- SW rs2=6 rs1=3 imm=12, then R-type rd=1 rs1=2 rs2=3 funct3=000 with funct7b5=0 and then 1 -> 0x0061A623, 0x003100B3, 0x403100B3 at addresses 1, 2, 3. in_ready is low during each WRITE.
- BEQ rs1=1 rs2=2 imm=-4 -> 0x FE208EE3. With ENC_IMM_CHECK_EN: BEQ imm=3 and LW imm=2048 -> err pulse each, no mem_we, count unchanged.
- ADDR_W=2, in_valid held high with five legal bundles -> four writes to addresses 0..3, then full=1, in_ready=0, count=4. The fifth bundle is never written.
- Reset asserted in the WRITE cycle of the second word -> mem_we=0 the next cycle, count=0. The next accepted word goes to address 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I LW/SW/R-type/BEQ field encoder and sequential instruction-memory loader.
// Optional macro ENC_IMM_CHECK_EN enables immediate range/alignment checking. Rev 1.0
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [12:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  localparam logic [1:0] KIND_LW  = 2'b00;
  localparam logic [1:0] KIND_SW  = 2'b01;
  localparam logic [1:0] KIND_R   = 2'b10;
  localparam logic [1:0] KIND_BEQ = 2'b11;

  // Value of count just before the final word commits.
  localparam logic [ADDR_W:0] LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;
  logic                full_q, full_d;

  logic [31:0]         enc_word;
  logic                legal;

  always_comb begin
    enc_word = 32'd0;
    case (in_kind)
      KIND_LW:  enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      KIND_SW:  enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      KIND_R:   enc_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
      KIND_BEQ: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default:  enc_word = 32'd0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  // LW/SW must fit a 12-bit signed value; branch targets must be halfword aligned.
  always_comb begin
    legal = 1'b1;
    case (in_kind)
      KIND_LW, KIND_SW: legal = (imm[12] == imm[11]);
      KIND_BEQ:         legal = (imm[0] == 1'b0);
      default:          legal = 1'b1;
    endcase
  end
`else
  logic unused_imm_lsb;
  assign unused_imm_lsb = imm[0];
  assign legal          = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    full_d      = full_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (legal) begin
            mem_wdata_d = enc_word;
            mem_addr_d  = wr_ptr_q;
            mem_we_d    = 1'b1;
            state_d     = S_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        count_d  = count_q + (ADDR_W + 1)'(1);
        if (count_q == LAST_COUNT) begin
          state_d = S_FULL;
          full_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FULL: begin
        state_d = S_FULL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      full_q      <= full_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector self-checking bench for instr_encoder (ADDR_W = 2). Rev 1.0
`default_nettype none

module tb_instr_encoder;

  localparam int ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [12:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int n_cmp;
  int n_bad;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_fields(input logic [1:0] k, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                            input logic [4:0] f_rs2, input logic [2:0] f3, input logic f7,
                            input logic [12:0] f_imm);
    in_kind  = k;
    rd       = f_rd;
    rs1      = f_rs1;
    rs2      = f_rs2;
    funct3   = f3;
    funct7b5 = f7;
    imm      = f_imm;
  endtask

  // Present the current bundle, wait for acceptance, then check the write cycle and commit.
  task automatic send(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_word);
    int n;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq({tag, "_we"},    32'(mem_we), 32'd1);
    check_eq({tag, "_addr"},  32'(mem_addr), exp_addr);
    check_eq({tag, "_wdata"}, mem_wdata, exp_word);
    check_eq({tag, "_rdy_lo"}, 32'(in_ready), 32'd0);
    tick();
    check_eq({tag, "_we_lo"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_count"}, 32'(count), exp_addr + 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "bench timed out");
  end

  initial begin
    int nw;
    logic acc;
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    set_fields(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);

    do_reset();
    check_eq("rst_we",    32'(mem_we), 32'd0);
    check_eq("rst_addr",  32'(mem_addr), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_full",  32'(full), 32'd0);
    check_eq("rst_err",   32'(err), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);

    // Basic encodings at consecutive addresses; fourth word fills the ADDR_W=2 memory.
    set_fields(2'b00, 5'd5, 5'd2, 5'd0, 3'd7, 1'b1, 13'd8);
    send("lw", 32'd0, 32'h0081_2283);
    set_fields(2'b01, 5'd9, 5'd3, 5'd6, 3'd7, 1'b1, 13'd12);
    send("sw", 32'd1, 32'h0061_A623);
    set_fields(2'b10, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 13'd0);
    send("add", 32'd2, 32'h0031_00B3);
    set_fields(2'b10, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 13'd0);
    send("sub", 32'd3, 32'h4031_00B3);
    check_eq("full_flag",  32'(full), 32'd1);
    check_eq("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("full_no_we", 32'(mem_we), 32'd0);
    end
    in_valid = 1'b0;
    check_eq("full_count", 32'(count), 32'd4);

    // BEQ with negative offset, then immediate edge cases.
    do_reset();
    set_fields(2'b11, 5'd0, 5'd1, 5'd2, 3'd7, 1'b1, 13'h1FFC);
    send("beq", 32'd0, 32'hFE20_8EE3);
`ifdef ENC_IMM_CHECK_EN
    set_fields(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("beq_odd_err", 32'(err), 32'd1);
    check_eq("beq_odd_we",  32'(mem_we), 32'd0);
    tick();
    check_eq("beq_odd_err_lo", 32'(err), 32'd0);
    check_eq("beq_odd_count",  32'(count), 32'd1);
    set_fields(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd2048);
    in_valid = 1'b1;
    tick();
    check_eq("lw_rng_err1", 32'(err), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("lw_rng_err2", 32'(err), 32'd1);
    check_eq("lw_rng_we",   32'(mem_we), 32'd0);
    tick();
    check_eq("lw_rng_count", 32'(count), 32'd1);
    check_eq("lw_rng_ready", 32'(in_ready), 32'd1);
`else
    set_fields(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd3);
    send("beq_trunc", 32'd1, 32'h0020_8163);
    check_eq("beq_trunc_err", 32'(err), 32'd0);
    set_fields(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd2048);
    send("lw_trunc", 32'd2, 32'h8000_2003);
    check_eq("lw_trunc_err", 32'(err), 32'd0);
`endif

    // Valid held high across five bundles: only four fit.
    do_reset();
    set_fields(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
    in_valid = 1'b1;
    nw = 0;
    for (int c = 0; c < 12; c++) begin
      acc = in_ready;
      tick();
      if (mem_we) begin
        check_eq("fill_addr",  32'(mem_addr), 32'(nw));
        check_eq("fill_wdata", mem_wdata, (32'(nw + 1) << 7) | 32'h0000_2003);
        nw++;
      end
      if (acc) rd = rd + 5'd1;
    end
    in_valid = 1'b0;
    check_eq("fill_writes", 32'(nw), 32'd4);
    check_eq("fill_full",   32'(full), 32'd1);
    check_eq("fill_ready",  32'(in_ready), 32'd0);
    check_eq("fill_count",  32'(count), 32'd4);

    // Reset during the WRITE cycle of the second word.
    do_reset();
    set_fields(2'b00, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 13'd8);
    send("pre", 32'd0, 32'h0081_2283);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("mid_we", 32'(mem_we), 32'd1);
    check_eq("mid_addr", 32'(mem_addr), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_we",    32'(mem_we), 32'd0);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    send("post", 32'd0, 32'h0081_2283);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
